// File: rtl/inv_factorial.sv
// rtl/inv_factorial.sv - inverse factorial: largest n with n! <= X by iterative multiply-and-compare
module inv_factorial #(
   parameter int W = 16
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         st,
   input  logic [W-1:0] X,
   output logic         busy,
   output logic         done,
   output logic [7:0]   n_out,
   output logic         exact,
   output logic         err
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   x_reg_q, x_reg_d;
   logic [7:0]     i_q, i_d;
   logic [W-1:0]   f_q, f_d;
   logic [7:0]     n_out_q, n_out_d;
   logic           exact_q, exact_d;
   logic           err_q, err_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic [W+7:0]   p;

   always_comb begin
      state_d = state_q;
      x_reg_d = x_reg_q;
      i_d     = i_q;
      f_d     = f_q;
      n_out_d = n_out_q;
      exact_d = exact_q;
      err_d   = err_q;
      // Full-width product so an overflowing candidate still compares as "too big"
      p = {8'd0, f_q} * ({{W{1'b0}}, i_q} + (W+8)'(1));
      case (state_q)
         IDLE: begin
            if (st) begin
               if (X != '0) begin
                  x_reg_d = X;
                  i_d     = 8'd1;
                  f_d     = W'(1);
                  state_d = RUN;
               end else begin
                  n_out_d = 8'd0;
                  exact_d = 1'b0;
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (p <= {8'd0, x_reg_q}) begin
               i_d = i_q + 8'd1;
               f_d = p[W-1:0];
            end else begin
               n_out_d = i_q;
               exact_d = (f_q == x_reg_q);
               err_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         x_reg_q <= '0;
         i_q     <= '0;
         f_q     <= '0;
         n_out_q <= '0;
         exact_q <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_reg_q <= x_reg_d;
         i_q     <= i_d;
         f_q     <= f_d;
         n_out_q <= n_out_d;
         exact_q <= exact_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign n_out = n_out_q;
   assign exact = exact_q;
   assign err   = err_q;

endmodule

// File: tb/tb_inv_factorial.sv
// tb/tb_inv_factorial.sv - directed-vector bench for inv_factorial
module tb_inv_factorial;

   logic        CLK;
   logic        RST;
   logic        st;
   logic [15:0] X;
   logic        busy;
   logic        done;
   logic [7:0]  n_out;
   logic        exact;
   logic        err;

   int n_tests;
   int n_fail;

   inv_factorial #(.W(16)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .st    (st),
      .X     (X),
      .busy  (busy),
      .done  (done),
      .n_out (n_out),
      .exact (exact),
      .err   (err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Returns the number of cycles (sampled at negedge) until done is seen, or -1
   task automatic wait_done(input int bound, output int cyc);
      cyc = -1;
      for (int c = 1; c <= bound; c++) begin
         @(negedge CLK);
         if (done) begin
            cyc = c;
            break;
         end
      end
   endtask

   task automatic run_job(input string tag, input logic [15:0] x, input int exp_n,
                          input int exp_exact, input int exp_err, input int exp_lat);
      int cyc;
      @(negedge CLK);
      st = 1'b1;
      X  = x;
      @(posedge CLK);
      #1;
      st = 1'b0;
      X  = 16'hA5A5;
      wait_done(40, cyc);
      check({tag, " latency"}, cyc, exp_lat);
      check({tag, " n_out"}, n_out, exp_n);
      check({tag, " exact"}, exact, exp_exact);
      check({tag, " err"}, err, exp_err);
      check({tag, " busy in DONE"}, busy, 1);
      @(negedge CLK);
      check({tag, " done one cycle"}, done, 0);
      check({tag, " idle after"}, busy, 0);
   endtask

   initial begin
      int cyc;
      n_tests = 0;
      n_fail  = 0;
      RST = 1'b0;
      st  = 1'b0;
      X   = '0;
      repeat (2) @(negedge CLK);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset n_out", n_out, 0);
      check("reset exact", exact, 0);
      check("reset err", err, 0);
      RST = 1'b1;

      run_job("x120", 16'd120, 5, 1, 0, 6);
      run_job("x121", 16'd121, 5, 0, 0, 6);
      run_job("x119", 16'd119, 4, 0, 0, 5);
      run_job("x0", 16'd0, 0, 0, 1, 1);
      run_job("x1", 16'd1, 1, 1, 0, 2);
      run_job("x65535", 16'd65535, 8, 0, 0, 9);
      run_job("x40320", 16'd40320, 8, 1, 0, 9);
      run_job("x2", 16'd2, 2, 1, 0, 3);

      // Ignored start while busy; results must hold until DONE
      @(negedge CLK);
      st = 1'b1;
      X  = 16'd720;
      @(posedge CLK);
      #1;
      st = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      st = 1'b1;
      X  = 16'd2;
      check("x720 n_out held mid-run", n_out, 2);
      @(negedge CLK);
      st = 1'b0;
      wait_done(40, cyc);
      check("x720 latency", cyc, 4);
      check("x720 n_out", n_out, 6);
      check("x720 exact", exact, 1);
      check("x720 busy in DONE", busy, 1);
      repeat (2) @(negedge CLK);
      check("x720 no queued job", busy, 0);

      // st held high: one IDLE cycle between jobs
      @(negedge CLK);
      st = 1'b1;
      X  = 16'd6;
      @(posedge CLK);
      #1;
      wait_done(20, cyc);
      check("hold first latency", cyc, 4);
      check("hold first n_out", n_out, 3);
      @(negedge CLK);
      check("hold gap idle", busy, 0);
      @(negedge CLK);
      check("hold restart busy", busy, 1);
      st = 1'b0;
      wait_done(20, cyc);
      check("hold second latency", cyc, 3);
      check("hold second n_out", n_out, 3);
      @(negedge CLK);

      // Asynchronous reset mid-RUN aborts without a done pulse
      @(negedge CLK);
      st = 1'b1;
      X  = 16'd5040;
      @(posedge CLK);
      #1;
      st = 1'b0;
      repeat (3) @(negedge CLK);
      #2;
      RST = 1'b0;
      #1;
      check("rst async busy", busy, 0);
      check("rst async n_out", n_out, 0);
      check("rst async exact", exact, 0);
      check("rst async err", err, 0);
      check("rst async done", done, 0);
      @(negedge CLK);
      RST = 1'b1;
      wait_done(10, cyc);
      check("rst no done pulse", cyc, -1);
      check("rst idle", busy, 0);
      run_job("x24", 16'd24, 4, 1, 0, 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inv_factorial.md
INV_FACTORIAL -- requirements
Module: inv_factorial

Interface
REQ-001 Parameter W, default 16: width of the operand X and of the internal factorial register.
REQ-002 CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 RST  input  1  asynchronous, active-low reset.
REQ-004 st  input  1  start request; sampled only in IDLE.
REQ-005 X  input  W  unsigned operand; sampled on the accepting edge only.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle completion pulse, registered.
REQ-008 n_out  output  8  largest n >= 1 with n! <= X; held until the next completion.
REQ-009 exact  output  1  1 when n_out! == X exactly; held with n_out.
REQ-010 err  output  1  1 when the last accepted X was 0; held with n_out.

Function
REQ-011 The block SHALL be the inverse of the factorial datapath: given X, it SHALL find n by iterative multiply-and-compare.
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with st=1 and X!=0 at an edge:
- capture X into x_reg;
- set i=1 and f=1;
- go to RUN.
REQ-014 IDLE with st=1 and X=0 at an edge: go to DONE with n_out=0, exact=0, err=1.
REQ-015 Each RUN cycle SHALL compute p = f*(i+1) at full width W+8 bits, with no truncation before the compare.
REQ-016 RUN with p <= x_reg: i <= i+1, f <= p[W-1:0], stay in RUN.
REQ-017 RUN with p > x_reg:
- n_out <= i;
- exact <= (f == x_reg);
- err <= 0;
- go to DONE.
REQ-018 done SHALL be 1 exactly during the cycle spent in DONE, and DONE SHALL always return to IDLE on the next edge.
REQ-019 Latency for a nonzero X with result n: done SHALL be high in the cycle that begins n+1 edges after the accepting edge (accept edge, then n-1 increment edges, then the terminating edge).
REQ-020 Latency for X=0: done SHALL be high in the cycle immediately after the accepting edge.
REQ-021 st SHALL be ignored in RUN and DONE; an ignored request SHALL NOT be queued.
REQ-022 X changes after the accepting edge SHALL NOT affect the current result.
REQ-023 n_out, exact and err SHALL update only on the edge entering DONE and SHALL be stable otherwise.
REQ-024 For W=16 the maximum result SHALL be n_out=8 (8! = 40320; 9! exceeds 2^16-1).
REQ-025 The 8-bit i SHALL NOT wrap for any W <= 32.
REQ-026 X=1 SHALL report n_out=1, exact=1 (by convention n=1 is preferred over 0!).
REQ-027 st held high continuously SHALL start a new computation on the edge after DONE returns to IDLE, i.e. one IDLE cycle between jobs.

Reset
REQ-028 RST=0 SHALL immediately, independent of CLK:
- force IDLE;
- clear x_reg, i, f;
- set n_out=0, exact=0, err=0, done=0, busy=0.
REQ-029 Reset asserted mid-RUN SHALL abort the computation; no done pulse SHALL follow reset release.
REQ-030 The first accepted st SHALL be on the first rising edge with RST=1.

Verification
REQ-031 X=120, st pulse -> done in the 6th cycle after accept; n_out=5, exact=1, err=0.
REQ-032 X=121 -> n_out=5, exact=0; X=119 -> n_out=4, exact=0.
REQ-033 X=0 -> done in the next cycle; err=1, n_out=0, exact=0. X=1 -> n_out=1, exact=1.
REQ-034 X=65535 (W=16) -> n_out=8, exact=0, done in the 9th cycle after accept. X=40320 -> n_out=8, exact=1.
REQ-035 With X=720 running:
- pulse st with X=2 while busy -> ignored; result n_out=6, exact=1;
- busy stays high through DONE.
REQ-036 RST low during RUN for X=5040, then release -> all outputs 0 and no done pulse; a new st with X=24 -> n_out=4, exact=1.
